// File: rtl/flag_buf_arb_pkg.sv
// Shared definitions for the flag buffer arbiter: buffer state names and the
// tag-width helper used by every file of this block.
package flag_buf_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  // Bits needed to index 'value' items; never less than one so a tag always exists.
  function automatic int clog2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    return (bits < 1) ? 1 : bits;
  endfunction

endpackage

// File: rtl/flag_buf_arb_if.sv
// Requester/consumer bus of the flag buffer arbiter. The master side is the
// requesters plus consumer; the slave side is the arbiter itself.
interface flag_buf_arb_if #(
  parameter int W = 8,
  parameter int N = 4
);
  localparam int TW = flag_buf_arb_pkg::clog2(N);

  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic           rd_ack;
  logic           flag;
  logic [W-1:0]   dout;
  logic [TW-1:0]  tag;
  logic [15:0]    busy_cnt;

  modport master (
    output req, din, rd_ack,
    input  gnt, flag, dout, tag, busy_cnt
  );

  modport slave (
    input  req, din, rd_ack,
    output gnt, flag, dout, tag, busy_cnt
  );

endinterface

// File: rtl/flag_buf_arb_flag_buf.sv
// Single-word buffer with a "holds unread data" flag. A set wins over a clear
// so a write and a read in the same cycle chain back-to-back.
module flag_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set_flag,
  input  logic         clr_flag,
  input  logic [W-1:0] din,
  output logic         flag,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag <= 1'b0;
      dout <= '0;
    end else if (set_flag) begin
      flag <= 1'b1;
      dout <= din;
    end else if (clr_flag) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/flag_buf_arb.sv
// Round-robin arbiter sharing one flag_buf among N requesters; the buffer flag
// itself is the EMPTY/FULL state, so no separate state register exists here.
module flag_buf_arb
  import flag_buf_arb_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input logic           clk,
  input logic           reset,
  flag_buf_arb_if.slave bus
);

  localparam int TW = clog2(N);

  logic [N-1:0]  eligible;
  logic [N-1:0]  gnt_q;
  logic [TW-1:0] rr_ptr;
  logic [TW-1:0] ptr_next;
  logic [TW-1:0] winner;
  logic [TW-1:0] tag_q;
  logic [15:0]   busy_q;
  logic          found;
  logic          set_flag;
  logic          clr_flag;
  logic          busy_inc;
  logic          flag;
  logic [W-1:0]  dout;
  logic [W-1:0]  win_word;
  buf_state_e    state;

  // A requester just granted still sees its req high this cycle; masking it
  // with gnt keeps it from winning twice on one request.
  always_comb begin
    logic [TW:0] idx;
    logic [TW:0] nxt;
    eligible = bus.req & ~gnt_q;
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, rr_ptr} + (TW+1)'(i);
      if (idx >= (TW+1)'(N)) idx = idx - (TW+1)'(N);
      if (!found && eligible[idx[TW-1:0]]) begin
        found  = 1'b1;
        winner = idx[TW-1:0];
      end
    end
    nxt = {1'b0, winner} + (TW+1)'(1);
    if (nxt == (TW+1)'(N)) nxt = '0;
    ptr_next = nxt[TW-1:0];
    win_word = bus.din[int'(winner)*W +: W];
  end

  always_comb begin
    state    = buf_state_e'(flag);
    set_flag = 1'b0;
    clr_flag = 1'b0;
    busy_inc = 1'b0;
    case (state)
      EMPTY: begin
        if (found) set_flag = 1'b1;
      end
      FULL: begin
        if (found && bus.rd_ack) set_flag = 1'b1;
        else if (bus.rd_ack)     clr_flag = 1'b1;
        else if (found)          busy_inc = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= '0;
      tag_q  <= '0;
      rr_ptr <= '0;
      busy_q <= '0;
    end else begin
      gnt_q <= '0;
      if (set_flag) begin
        gnt_q[winner] <= 1'b1;
        tag_q         <= winner;
        rr_ptr        <= ptr_next;
      end
      if (busy_inc && busy_q != 16'hFFFF) busy_q <= busy_q + 16'd1;
    end
  end

  flag_buf #(.W(W)) u_flag_buf (
    .clk      (clk),
    .reset    (reset),
    .set_flag (set_flag),
    .clr_flag (clr_flag),
    .din      (win_word),
    .flag     (flag),
    .dout     (dout)
  );

  assign bus.gnt      = gnt_q;
  assign bus.flag     = flag;
  assign bus.dout     = dout;
  assign bus.tag      = tag_q;
  assign bus.busy_cnt = busy_q;

endmodule

// File: tb/tb_flag_buf_arb.sv
// Bench for flag_buf_arb: directed scenarios followed by random requester and
// consumer traffic, all compared against a transaction-level model.
module tb_flag_buf_arb;
  import flag_buf_arb_pkg::*;

  localparam int W = 8;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  flag_buf_arb_if #(.W(W), .N(N)) bus ();

  flag_buf_arb #(.W(W), .N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic         m_flag;
  logic [W-1:0] m_dout;
  int           m_tag;
  int           m_ptr;
  logic [N-1:0] m_gnt;
  int           m_busy;

  logic [N-1:0]   pending;
  logic [N-1:0]   lag;
  logic [W-1:0]   word [N];
  logic [N*W-1:0] din_v;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flag = 1'b0;
    m_dout = '0;
    m_tag  = 0;
    m_ptr  = 0;
    m_gnt  = '0;
    m_busy = 0;
  endtask

  // One cycle of the buffer's rules applied to the inputs currently driven.
  task automatic model_step();
    int win;
    int idx;
    win = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (win < 0 && bus.req[idx] && !m_gnt[idx]) win = idx;
    end
    if (win >= 0 && (!m_flag || bus.rd_ack)) begin
      m_flag = 1'b1;
      m_dout = bus.din[win*W +: W];
      m_tag  = win;
      m_gnt  = N'(1) << win;
      m_ptr  = (win + 1) % N;
    end else begin
      m_gnt = '0;
      if (m_flag && bus.rd_ack) m_flag = 1'b0;
      else if (m_flag && win >= 0 && m_busy < 65535) m_busy = m_busy + 1;
    end
  endtask

  task automatic check_all();
    check_output("flag", 32'(bus.flag), 32'(m_flag));
    check_output("dout", 32'(bus.dout), 32'(m_dout));
    check_output("tag", 32'(bus.tag), 32'(m_tag));
    check_output("gnt", 32'(bus.gnt), 32'(m_gnt));
    check_output("busy_cnt", 32'(bus.busy_cnt), 32'(m_busy));
  endtask

  task automatic apply_stimulus(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic ack);
    bus.req    = r;
    bus.din    = d;
    bus.rd_ack = ack;
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge arrives.
  task automatic do_reset();
    reset      = 1'b1;
    bus.req    = '0;
    bus.rd_ack = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    bus.req    = '0;
    bus.din    = '0;
    bus.rd_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all();

    apply_stimulus('0, '0, 1'b0);
    check_output("no_gnt_after_reset", 32'(bus.gnt), 32'h0);

    din_v = '0;
    din_v[2*W +: W] = 8'h5A;
    apply_stimulus(4'b0100, din_v, 1'b0);
    check_output("single_gnt", 32'(bus.gnt), 32'h4);
    check_output("single_dout", 32'(bus.dout), 32'h5A);
    check_output("single_tag", 32'(bus.tag), 32'h2);

    repeat (5) apply_stimulus(4'b0011, din_v, 1'b0);
    check_output("full_busy", 32'(bus.busy_cnt), 32'd5);
    check_output("full_dout", 32'(bus.dout), 32'h5A);

    din_v[W +: W] = 8'hC3;
    apply_stimulus(4'b0010, din_v, 1'b1);
    check_output("b2b_flag", 32'(bus.flag), 32'h1);
    check_output("b2b_dout", 32'(bus.dout), 32'hC3);
    check_output("b2b_tag", 32'(bus.tag), 32'h1);

    apply_stimulus('0, din_v, 1'b1);
    check_output("clr_flag", 32'(bus.flag), 32'h0);
    check_output("clr_dout", 32'(bus.dout), 32'hC3);
    apply_stimulus('0, din_v, 1'b1);

    do_reset();
    din_v = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      apply_stimulus(4'hF, din_v, 1'b1);
      check_output("rr_tag", 32'(bus.tag), 32'(k % 4));
      check_output("rr_dout", 32'(bus.dout), 32'h10 + 32'(k % 4));
    end

    repeat (7) apply_stimulus(4'b0011, din_v, 1'b0);
    check_output("busy_seven", 32'(bus.busy_cnt), 32'd7);
    #3;
    do_reset();
    apply_stimulus('0, din_v, 1'b0);
    check_output("no_gnt_after_release", 32'(bus.gnt), 32'h0);

    pending = '0;
    lag     = '0;
    for (int i = 0; i < N; i++) word[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (bus.gnt[i]) begin
          pending[i] = 1'b0;
          lag[i]     = 1'($urandom_range(0, 1));
        end else begin
          lag[i] = 1'b0;
          if (!pending[i] && $urandom_range(0, 2) == 0) begin
            pending[i] = 1'b1;
            word[i]    = 8'($urandom);
          end
        end
        din_v[i*W +: W] = word[i];
      end
      if (cyc < 300) apply_stimulus(pending | lag, din_v, $urandom_range(0, 3) != 0);
      else           apply_stimulus(pending | lag, din_v, $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flag_buf_arb.md
FLAG_BUF_ARB -- requirements
Module: flag_buf_arb

Interface
REQ-001 Parameter W, default 8: data width of each requester word and of the buffer.
REQ-002 Parameter N, default 4: number of requesters (2..8); TW = clog2(N) is the tag width.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  N  per-requester write request, level; held until the matching gnt bit is seen.
REQ-006 din  input  N*W  requester data; requester i occupies bits [i*W +: W], stable while req[i]=1.
REQ-007 gnt  output  N  one-hot, registered, one-cycle pulse; requester i's word was accepted.
REQ-008 rd_ack  input  1  consumer has taken the buffered word; clears the flag.
REQ-009 flag  output  1  buffer holds an unread word.
REQ-010 dout  output  W  buffered word; valid while flag=1.
REQ-011 tag  output  TW  index of the requester that wrote dout; valid while flag=1.
REQ-012 busy_cnt  output  16  saturating count of cycles where any eligible req was pending while the buffer was full.

Function
REQ-013 SHALL share one flag_buf instance (set_flag, clr_flag, din, flag, dout) among N requesters.
REQ-014 FSM states: EMPTY (flag=0) and FULL (flag=1); the state is the flag_buf flag bit, with no separate state register.
REQ-015 Eligible set = req AND NOT gnt; a requester granted this cycle SHALL NOT win again in the same cycle.
REQ-016 Write occurs in cycle t when (flag=0 OR rd_ack=1) and the eligible set is non-empty.
REQ-017 Winner = first eligible index at or after rr_ptr, searching upward with wrap-around modulo N.
REQ-018 On a write in cycle t:
  - set_flag=1 and din=winner's word in cycle t.
  - At t+1: flag=1, dout=word, tag=winner, gnt[winner]=1 for exactly one cycle.
  - rr_ptr=(winner+1) mod N at t+1.
REQ-019 rd_ack=1 with no eligible request: clr_flag=1; flag=0 at t+1; dout and tag retain their old values.
REQ-020 rd_ack=1 with an eligible request in the same cycle: the set takes priority; flag stays 1 and dout/tag load the new word at t+1 (back-to-back, zero bubble).
REQ-021 rd_ack while flag=0: ignored, no state change.
REQ-022 flag=1, no rd_ack: no write; requests stay pending; busy_cnt increments if the eligible set is non-empty, saturating at 0xFFFF.
REQ-023 Fairness: a continuously requesting requester SHALL be granted within N writes.
REQ-024 Throughput: at most one write per cycle; sustained rate is 1 word/cycle when rd_ack is held high.

Reset
REQ-025 On reset, regardless of operation in progress:
  - flag=0, dout=0, tag=0, gnt=0, rr_ptr=0, busy_cnt=0.
  - Any pending request is dropped and must be re-presented.
REQ-026 Reset deassertion SHALL NOT by itself produce a grant; the first possible write is the first rising edge after deassertion with req≠0.

Structure
REQ-027 TW computation (clog2 function) SHALL live in the shared project include file; the FSM needs no encoding constants.
REQ-028 Exactly one sub-module: flag_buf (parameter W), holding buffer data and flag.
REQ-029 Tag register, rr_ptr, gnt register, priority search and busy_cnt SHALL reside in flag_buf_arb.

Verification
REQ-030 After reset, req=4'b0100, din[2]=0x5A -> at edge+1: gnt=4'b0100, flag=1, dout=0x5A, tag=2; rr_ptr=3.
REQ-031 req=4'b1111 held, rd_ack tied 1, data i=0x10+i -> grants in order 0,1,2,3,0; dout 0x10,0x11,0x12,0x13,0x10 on consecutive cycles.
REQ-032 flag=1, rd_ack=0, req=4'b0011 held for 5 cycles -> no gnt; busy_cnt=5; dout unchanged.
REQ-033 flag=1, rd_ack=1 with req=0 -> flag=0 next cycle; dout/tag unchanged.
REQ-034 flag=1, rd_ack=1 with req=4'b0010 in the same cycle -> flag remains 1; dout=din[1] and tag=1 next cycle.
REQ-035 Reset asserted mid-stream with flag=1, busy_cnt=7 -> all outputs 0 immediately (asynchronous); no gnt on the first edge after release if req=0.
